// File: rtl/io_bus_pkg.sv
// Shared encodings and helpers for the 16-bit-address / 64-bit-data IO bus.
package io_bus_pkg;

  localparam logic [1:0] IoSizeB = 2'd0;
  localparam logic [1:0] IoSizeW = 2'd1;
  localparam logic [1:0] IoSizeD = 2'd2;
  localparam logic [1:0] IoSizeQ = 2'd3;

  localparam logic [1:0] IoErrOk    = 2'd0;
  localparam logic [1:0] IoErrAddr  = 2'd1;
  localparam logic [1:0] IoErrTout  = 2'd2;
  localparam logic [1:0] IoErrAlign = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } io_state_e;

  function automatic logic [3:0] io_strobe(input logic [1:0] size);
    io_strobe = 4'b0001 << size;
  endfunction

  function automatic logic [63:0] io_mask(input logic [1:0] size);
    case (size)
      IoSizeB: io_mask = 64'h0000_0000_0000_00FF;
      IoSizeW: io_mask = 64'h0000_0000_0000_FFFF;
      IoSizeD: io_mask = 64'h0000_0000_FFFF_FFFF;
      default: io_mask = '1;
    endcase
  endfunction

endpackage

// File: rtl/io_bus_align_chk.sv
// Combinational request decode: misalignment test, one-hot strobe and data mask.
module io_bus_align_chk
  import io_bus_pkg::*;
(
  input  logic [2:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  output logic        o_misalign,
  output logic [3:0]  o_strobe,
  output logic [63:0] o_mask
);

  logic [2:0] w_lo_mask;

  always_comb begin
    case (i_size)
      IoSizeB: w_lo_mask = 3'b000;
      IoSizeW: w_lo_mask = 3'b001;
      IoSizeD: w_lo_mask = 3'b011;
      default: w_lo_mask = 3'b111;
    endcase
  end

  assign o_misalign = |(i_addr_lo & w_lo_mask);
  assign o_strobe   = io_strobe(i_size);
  assign o_mask     = io_mask(i_size);

endmodule

// File: rtl/io_bus_master.sv
// IO bus initiator: one bus access per core request, status-coded response.
// Optional error flag/counter ports are built when IO_BUS_MASTER_ERR_IRQ_EN is defined.
module io_bus_master
  import io_bus_pkg::*;
#(
  parameter int unsigned CAddrBits = 16,
  parameter int unsigned CToutCnt  = 4
) (
  input  logic                 AClkH,
  input  logic                 AResetHN,
  input  logic                 AClkHEn,
  input  logic                 AReqValid,
  output logic                 AReqReady,
  input  logic [CAddrBits-1:0] AReqAddr,
  input  logic                 AReqWr,
  input  logic [1:0]           AReqSize,
  input  logic [63:0]          AReqWrData,
  output logic                 ARspValid,
  input  logic                 ARspReady,
  output logic [63:0]          ARspRdData,
  output logic [1:0]           ARspErr,
  output logic [CAddrBits-1:0] AIoAddr,
  output logic [63:0]          AIoMosi,
  output logic [3:0]           AIoWrSize,
  output logic [3:0]           AIoRdSize,
  input  logic [63:0]          AIoMiso,
  input  logic                 AIoAddrAck,
  input  logic                 AIoAddrErr
`ifdef IO_BUS_MASTER_ERR_IRQ_EN
  ,
  output logic                 AErrIrq,
  input  logic                 AErrClr,
  output logic [7:0]           AErrCnt
`endif
);

  io_state_e            r_state;
  logic                 r_req_ready;
  logic                 r_wr;
  logic [63:0]          r_rd_mask;
  logic [3:0]           r_tout_cnt;
  logic                 r_rsp_valid;
  logic [63:0]          r_rsp_rd_data;
  logic [1:0]           r_rsp_err;
  logic [CAddrBits-1:0] r_io_addr;
  logic [63:0]          r_io_mosi;
  logic [3:0]           r_io_wr_size;
  logic [3:0]           r_io_rd_size;

  logic                 w_misalign;
  logic [3:0]           w_strobe;
  logic [63:0]          w_mask;
  logic                 w_accept;
  logic                 w_tout;

  io_bus_align_chk u_align_chk (
    .i_addr_lo  (AReqAddr[2:0]),
    .i_size     (AReqSize),
    .o_misalign (w_misalign),
    .o_strobe   (w_strobe),
    .o_mask     (w_mask)
  );

  assign w_accept = (r_state == StIdle) && r_req_ready && AReqValid;
  assign w_tout   = (r_tout_cnt == 4'(CToutCnt - 1));

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_state       <= StIdle;
      r_req_ready   <= 1'b0;
      r_wr          <= 1'b0;
      r_rd_mask     <= '0;
      r_tout_cnt    <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rd_data <= '0;
      r_rsp_err     <= IoErrOk;
      r_io_addr     <= '0;
      r_io_mosi     <= '0;
      r_io_wr_size  <= '0;
      r_io_rd_size  <= '0;
    end else if (AClkHEn) begin
      case (r_state)
        StIdle: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_wr        <= AReqWr;
            r_rd_mask   <= w_mask;
            r_tout_cnt  <= '0;
            // Misaligned requests never touch the bus; address/data outputs keep old values.
            if (w_misalign) begin
              r_rsp_err     <= IoErrAlign;
              r_rsp_rd_data <= '0;
              r_rsp_valid   <= 1'b1;
              r_state       <= StResp;
            end else begin
              r_io_addr <= AReqAddr;
              r_io_mosi <= AReqWrData;
              if (AReqWr) r_io_wr_size <= w_strobe;
              else        r_io_rd_size <= w_strobe;
              r_state <= StAccess;
            end
          end
        end
        StAccess: begin
          if (AIoAddrErr || AIoAddrAck || w_tout) begin
            r_io_wr_size <= '0;
            r_io_rd_size <= '0;
            r_rsp_valid  <= 1'b1;
            r_state      <= StResp;
            if (AIoAddrErr) begin
              r_rsp_err     <= IoErrAddr;
              r_rsp_rd_data <= '0;
            end else if (AIoAddrAck) begin
              r_rsp_err     <= IoErrOk;
              r_rsp_rd_data <= r_wr ? '0 : (AIoMiso & r_rd_mask);
            end else begin
              r_rsp_err     <= IoErrTout;
              r_rsp_rd_data <= '0;
            end
          end else begin
            r_tout_cnt <= r_tout_cnt + 4'd1;
          end
        end
        StResp: begin
          if (ARspReady) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign AReqReady  = r_req_ready;
  assign ARspValid  = r_rsp_valid;
  assign ARspRdData = r_rsp_rd_data;
  assign ARspErr    = r_rsp_err;
  assign AIoAddr    = r_io_addr;
  assign AIoMosi    = r_io_mosi;
  assign AIoWrSize  = r_io_wr_size;
  assign AIoRdSize  = r_io_rd_size;

`ifdef IO_BUS_MASTER_ERR_IRQ_EN
  logic       w_err_set;
  logic       r_err_irq;
  logic [7:0] r_err_cnt;

  assign w_err_set = AClkHEn &&
                     ((w_accept && w_misalign) ||
                      ((r_state == StAccess) && (AIoAddrErr || (!AIoAddrAck && w_tout))));

  // A new error on the same edge as a clear wins: flag stays set, count restarts at one.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_err_irq <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_err_set) begin
      r_err_irq <= 1'b1;
      if (AErrClr)                r_err_cnt <= 8'd1;
      else if (r_err_cnt != '1)   r_err_cnt <= r_err_cnt + 8'd1;
    end else if (AClkHEn && AErrClr) begin
      r_err_irq <= 1'b0;
      r_err_cnt <= '0;
    end
  end

  assign AErrIrq = r_err_irq;
  assign AErrCnt = r_err_cnt;
`endif

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator end of the 16-bit-address / 64-bit-data IO bus.
- Accepts single read/write requests from a core-side valid/ready port and drives one bus access per request.
- Samples the responders' OR-combined AIoMiso, AIoAddrAck and AIoAddrErr, and returns read data plus a status code.
- Sits between the CPU load/store unit and the IO peripheral fabric.

Parameters:
- CAddrBits, 16, IO address width.
- CToutCnt, 4, enabled cycles to wait for ack/err before declaring "no responder" (1..15).

Ports:
- AClkH  in  1  clock; single clock domain.
- AResetHN  in  1  asynchronous active-low reset.
- AClkHEn  in  1  clock enable; state advances only on enabled edges.
- AReqValid  in  1  request valid.
- AReqReady  out  1  request accepted this enabled edge when AReqValid=1.
- AReqAddr  in  CAddrBits  byte address.
- AReqWr  in  1  1=write, 0=read.
- AReqSize  in  2  0=byte, 1=word, 2=dword, 3=qword.
- AReqWrData  in  64  write data, right-aligned.
- ARspValid  out  1  response valid.
- ARspReady  in  1  response taken.
- ARspRdData  out  64  read data, zero-masked to the access size.
- ARspErr  out  2  0=ok, 1=AddrErr, 2=timeout/no responder, 3=misaligned.
- AIoAddr  out  CAddrBits  bus address.
- AIoMosi  out  64  bus write data.
- AIoWrSize  out  4  one-hot write strobe; bit n = 2^n bytes.
- AIoRdSize  out  4  one-hot read strobe, same encoding.
- AIoMiso  in  64  OR-combined responder read data.
- AIoAddrAck  in  1  some responder claims the address.
- AIoAddrErr  in  1  responder rejects (wrong size/op).

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async): state IDLE. AReqReady=0. ARspValid=0. ARspRdData=0. ARspErr=0. AIoAddr=0. AIoMosi=0. AIoWrSize=0. AIoRdSize=0. Timeout counter=0.

IDLE:
- AReqReady=1.
- On an enabled edge with AReqValid, latch addr, wr, size and data.
- Misalignment is defined as AReqAddr mod 2^AReqSize != 0. On misalignment, go to RESP with Err=3 and do not drive the bus. Otherwise go to ACCESS.

ACCESS:
- Drive AIoAddr and AIoMosi.
- Drive exactly one strobe bit = 1<<size, on AIoWrSize if wr, else on AIoRdSize.
- On each enabled edge:
  - AIoAddrErr=1 -> Err=1 (takes priority over ack).
  - Else AIoAddrAck=1 -> Err=0; for reads, capture AIoMiso masked to 8/16/32/64 bits.
  - Else increment the timeout counter; at CToutCnt -> Err=2.
- Any of these terminations goes to RESP and zeroes the strobes in the same edge.
- A write commits in responders exactly on the terminating enabled edge.
- Strobes held across disabled cycles are legal. Minimum latency is request accept to ARspValid = 2 enabled edges.

RESP:
- ARspValid=1; data and Err stable until an enabled edge with ARspReady=1, then go to IDLE.
- AReqReady=0 during ACCESS and RESP; at most one transaction outstanding.
- Write responses: ARspRdData=0.
- Bus outputs other than strobes hold their last values when idle; strobes are 0 whenever not in ACCESS.
- Reset mid-ACCESS: strobes drop immediately (async); the transaction is lost and no response is issued.

Optional Feature:
- IO_BUS_MASTER_ERR_IRQ_EN defined:
  - Adds ports AErrIrq out 1 and AErrClr in 1.
  - Sticky flag set on any response with Err!=0. Cleared by AErrClr on an enabled edge; a set in the same edge wins.
  - Adds an 8-bit saturating error counter readable on AErrCnt out 8, cleared with the flag.
- Undefined: none of these ports or registers exist.

Decomposition:
- Package io_bus_pkg holds:
  - size encoding constants (IoSizeB/W/D/Q);
  - error-code constants (IoErrOk/Addr/Tout/Align);
  - FSM state enum;
  - function returning the one-hot strobe from a 2-bit size;
  - function returning the 64-bit data mask from a 2-bit size.
- One sub-module is natural: io_bus_align_chk (combinational misalign check plus strobe and mask generation).

Test Plan:
- Read dword 0x0100; responder acks with Miso=0xDEADBEEF_12345678 -> AIoRdSize=4'b0100 for one enabled cycle, then ARspValid, RdData=0x12345678, Err=0.
- Write word 0x0102, data 0xABCD; ack -> AIoWrSize=4'b0010 once, responder register becomes 0xABCD, Err=0, RdData=0.
- Read byte 0x0200 with no ack and CToutCnt=4 -> strobe held 4 enabled cycles, then Err=2 and strobes 0.
- Read dword 0x0102 -> no strobe ever asserted, response Err=3 after 1 edge.
- Ack and AddrErr both high -> Err=1. Hold ARspReady=0 for 5 cycles -> response stable, AReqReady=0 throughout.
- AClkHEn toggling 1-of-3 during a write -> exactly one register update. Reset asserted in ACCESS -> strobes 0 immediately, no response.
